// File: rtl/geofence_feeder.sv
// Initiator for the geofence point stream: buffers one job, streams it on X/Y, returns the verdict.
// Latency: first point 1 cycle after start, result at least NPTS+3 cycles after start; no backpressure.
module geofence_feeder #(
  parameter int CW      = 10,
  parameter int NPTS    = 6,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  logic          start,
  output logic          busy,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  input  logic          valid,
  input  logic          is_inside,
  output logic          res_valid,
  output logic          res_inside,
  output logic          res_timeout,
  output logic          proto_err
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0]     LAST_IDX = 3'(NPTS);
  localparam logic [WCW-1:0] WLAST    = WCW'(TIMEOUT - 1);

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pt_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state_q;
  pt_t            mem_q [0:NPTS];
  logic [2:0]     idx_q;
  logic [2:0]     nxt_idx;
  logic [WCW-1:0] wcnt_q;
  pt_t            out_q;
  logic           res_valid_q;
  logic           res_inside_q;
  logic           res_timeout_q;
  logic           proto_err_q;

  assign nxt_idx = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wcnt_q        <= '0;
      out_q         <= '0;
      res_valid_q   <= 1'b0;
      res_inside_q  <= 1'b0;
      res_timeout_q <= 1'b0;
      proto_err_q   <= 1'b0;
      for (int i = 0; i <= NPTS; i++) mem_q[i] <= '0;
    end else begin
      res_valid_q <= 1'b0;
      // A result strobe is only legal while we are waiting for it.
      if (valid && state_q != WAIT) proto_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (wr_en && wr_addr <= LAST_IDX) mem_q[wr_addr] <= {wr_x, wr_y};
          if (start) begin
            state_q <= SEND;
            idx_q   <= '0;
            out_q   <= mem_q[0];
          end
        end
        SEND: begin
          if (idx_q == LAST_IDX) begin
            state_q <= WAIT;
            out_q   <= '0;
            wcnt_q  <= '0;
          end else begin
            idx_q <= nxt_idx;
            out_q <= mem_q[nxt_idx];
          end
        end
        WAIT: begin
          // A strobe on the final allowed cycle still beats the timeout.
          if (valid) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b1;
            res_inside_q  <= is_inside;
            res_timeout_q <= 1'b0;
          end else if (wcnt_q == WLAST) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b1;
            res_inside_q  <= 1'b0;
            res_timeout_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign X           = out_q.x;
  assign Y           = out_q.y;
  assign res_valid   = res_valid_q;
  assign res_inside  = res_inside_q;
  assign res_timeout = res_timeout_q;
  assign proto_err   = proto_err_q;

endmodule
